// File: rtl/elm_param_loader_pkg.sv
// Shared definitions for the hidden-layer parameter loader.
//   state_t    : loader FSM state encoding (ST_IDLE..ST_FINISH)
//   cfg_width  : width of the config_layer_num / config_neuron_num buses
//   cnt_width  : bit width needed to hold a count in 0..modulus-1
package elm_param_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WEIGHT = 3'd2,
        ST_BIAS   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // The neuron config ports are sized 2*dataWidth+1 by the neuron design.
    function automatic int cfg_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

    // A modulus of 1 still needs a one-bit register.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/elm_param_counter.sv
// Wrap counter with terminal-count flag, used for the weight index and the
// neuron index of the loader.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to zero (wins over inc)
//   inc      : advance by one, wrapping from MODULUS-1 to 0
//   count    : current count
//   tc       : count == MODULUS-1
module elm_param_counter
    import elm_param_loader_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    assign tc    = (count_reg == WIDTH'(MODULUS - 1));
    assign count = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/elm_param_loader.sv
// Loads one hidden layer's weights and biases from a host word stream into
// the layer's neuron array.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : pulse to begin a load (ignored unless idle)
//   s_data/s_valid/s_last/s_ready : host word stream
//   neuron_clr          : one-cycle clear of the neurons' write pointers
//   weightValue/weightValid : broadcast weight write strobe
//   bias_value/bias_valid   : bias word with one-hot per-neuron strobe
//   config_layer_num/config_neuron_num : registered write address
//   busy, done          : load in progress / one-cycle end-of-load pulse
//   err_last            : sticky misplaced-s_last flag, cleared by start
// Stream layout per neuron: NUM_WEIGHT weights followed by one bias.
module elm_param_loader
    import elm_param_loader_pkg::*;
#(
    parameter int  DATA_WIDTH  = 16,
    parameter int  NUM_WEIGHT  = 128,
    parameter int  NUM_NEURONS = 32,
    parameter int  LAYER_NO    = 1,
    parameter int  NEURON_BASE = 0,
    localparam int CFG_W       = cfg_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   neuron_clr,
    output logic [DATA_WIDTH-1:0]  weightValue,
    output logic                   weightValid,
    output logic [DATA_WIDTH-1:0]  bias_value,
    output logic [NUM_NEURONS-1:0] bias_valid,
    output logic [CFG_W-1:0]       config_layer_num,
    output logic [CFG_W-1:0]       config_neuron_num,
    output logic                   busy,
    output logic                   done,
    output logic                   err_last
);

    localparam int W_W = cnt_width(NUM_WEIGHT);
    localparam int N_W = cnt_width(NUM_NEURONS);

    state_t state_reg, state_next;

    logic           accept;
    logic           start_take;
    logic           w_inc, n_inc;
    logic [W_W-1:0] w_cnt;
    logic [N_W-1:0] n_cnt;
    logic           w_tc, n_tc;
    logic           final_bias;
    logic           err_last_next;

    logic [DATA_WIDTH-1:0]  weight_value_reg;
    logic                   weight_valid_reg;
    logic [DATA_WIDTH-1:0]  bias_value_reg;
    logic [NUM_NEURONS-1:0] bias_valid_reg;
    logic [NUM_NEURONS-1:0] bias_hit;
    logic [CFG_W-1:0]       layer_num_reg;
    logic [CFG_W-1:0]       neuron_num_reg;
    logic                   err_last_reg;

    assign accept     = s_valid & s_ready;
    assign start_take = (state_reg == ST_IDLE) & start;
    assign w_inc      = accept & (state_reg == ST_WEIGHT);
    assign n_inc      = accept & (state_reg == ST_BIAS);
    assign final_bias = (state_reg == ST_BIAS) & n_tc;

    elm_param_counter #(.MODULUS(NUM_WEIGHT)) u_w_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_take),
        .inc   (w_inc),
        .count (w_cnt),
        .tc    (w_tc)
    );

    elm_param_counter #(.MODULUS(NUM_NEURONS)) u_n_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_take),
        .inc   (n_inc),
        .count (n_cnt),
        .tc    (n_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. An s_last anywhere before the final bias beat aborts
    // the load after that beat has been forwarded.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = ST_WEIGHT;
            ST_WEIGHT: begin
                if (accept) begin
                    if (s_last)    state_next = ST_FINISH;
                    else if (w_tc) state_next = ST_BIAS;
                end
            end
            ST_BIAS: begin
                if (accept) begin
                    if (n_tc || s_last) state_next = ST_FINISH;
                    else                state_next = ST_WEIGHT;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready    = 1'b0;
        neuron_clr = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                neuron_clr = 1'b1;
                busy       = 1'b1;
            end
            ST_WEIGHT, ST_BIAS: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    // Sticky error: set on a misplaced s_last or a final bias without it.
    always_comb begin
        err_last_next = err_last_reg;
        if (start_take) begin
            err_last_next = 1'b0;
        end else if (accept && (s_last != final_bias)) begin
            err_last_next = 1'b1;
        end
    end

    // One-hot decode of the current neuron index for the bias strobe.
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_bias_hit
        assign bias_hit[gi] = (n_cnt == N_W'(gi));
    end

    // Strobes and address are captured on the same edge so the address is
    // valid whenever a strobe is high; the address holds between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_value_reg <= '0;
            weight_valid_reg <= 1'b0;
            bias_value_reg   <= '0;
            bias_valid_reg   <= '0;
            layer_num_reg    <= '0;
            neuron_num_reg   <= '0;
            err_last_reg     <= 1'b0;
        end else begin
            weight_valid_reg <= w_inc;
            bias_valid_reg   <= n_inc ? bias_hit : '0;
            err_last_reg     <= err_last_next;
            if (w_inc) begin
                weight_value_reg <= s_data;
            end
            if (n_inc) begin
                bias_value_reg <= s_data;
            end
            if (accept) begin
                layer_num_reg  <= CFG_W'(LAYER_NO);
                neuron_num_reg <= CFG_W'(NEURON_BASE) + CFG_W'(n_cnt);
            end
        end
    end

    assign weightValue       = weight_value_reg;
    assign weightValid       = weight_valid_reg;
    assign bias_value        = bias_value_reg;
    assign bias_valid        = bias_valid_reg;
    assign config_layer_num  = layer_num_reg;
    assign config_neuron_num = neuron_num_reg;
    assign err_last          = err_last_reg;

endmodule

// File: doc/elm_param_loader.md
Name: elm_param_loader

Overview:
- Loads one hidden layer's trained weights and biases into its neuron array.
- Consumes a host word stream (valid/ready, with last) and drives the neurons' broadcast weight-write bus: weightValue/weightValid plus config_layer_num/config_neuron_num addressing.
- Drives a one-hot bias strobe per neuron, because a neuron captures bias on biasValid without checking its address.
- Sits between the AXI-stream DMA front end and the layer's neuron instances.

Parameters:
- DATA_WIDTH, 16, width of weight/bias words (equals `dataWidth).
- NUM_WEIGHT, 128, weights per neuron.
- NUM_NEURONS, 32, neurons in the target layer.
- LAYER_NO, 1, value driven on config_layer_num.
- NEURON_BASE, 0, neuron number of the first neuron in the layer.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  one-cycle pulse that begins a layer load; ignored while busy
- s_data  in  DATA_WIDTH  stream word, weight or bias
- s_valid  in  1  stream word valid
- s_last  in  1  marks the final word of the layer image
- s_ready  out  1  loader accepts a word this cycle
- neuron_clr  out  1  one-cycle active-high clear to the neurons' sync rst, which re-zeroes their write pointers
- weightValue  out  DATA_WIDTH  weight word
- weightValid  out  1  weight strobe, broadcast to all neurons
- bias_value  out  DATA_WIDTH  bias word
- bias_valid  out  NUM_NEURONS  one-hot bias strobe, bit i goes to neuron i
- config_layer_num  out  2*DATA_WIDTH+1  target layer
- config_neuron_num  out  2*DATA_WIDTH+1  target neuron number
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the load ends
- err_last  out  1  sticky flag: s_last misplaced; cleared by the next start

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0, all outputs are 0 (config_* = 0, bias_valid = 0, err_last = 0) and the FSM is in IDLE.
- FSM states: IDLE, CLEAR, WEIGHT, BIAS, FINISH.
- IDLE: s_ready=0.
  - start → CLEAR, with busy=1, err_last=0, w_cnt=0, n_cnt=0.
- CLEAR: neuron_clr=1 for exactly 1 cycle, s_ready=0, then → WEIGHT.
- WEIGHT: s_ready=1. On each accepted beat (s_valid&s_ready):
  - Next cycle: weightValue=s_data and weightValid=1 for one cycle.
  - w_cnt increments. When w_cnt reaches NUM_WEIGHT-1 on an accepted beat, w_cnt → 0 and the FSM → BIAS.
- BIAS: s_ready=1. On an accepted beat:
  - Next cycle: bias_value=s_data and bias_valid[n_cnt]=1 for one cycle.
  - If n_cnt==NUM_NEURONS-1 → FINISH; otherwise n_cnt++ and → WEIGHT.
- FINISH: s_ready=0, done=1 for one cycle, busy=0, then → IDLE.
- Addressing: config_layer_num=LAYER_NO and config_neuron_num=NEURON_BASE+n_cnt, zero-extended and registered. Both are updated on the same edge that issues the strobe, so they are stable whenever weightValid or bias_valid is high. They hold their last value in IDLE.
- Latency: accepted beat to strobe is 1 cycle. Back-to-back beats give back-to-back strobes (full throughput). Bubbles on s_valid only delay the sequence; no strobe is issued without an accepted beat.
- s_last checking:
  - Expected only on the final bias beat (last neuron, BIAS).
  - s_last on any earlier accepted beat: that beat is still forwarded, err_last is set, and the FSM → FINISH (abort, done pulses).
  - Final bias beat without s_last: err_last is set and the load completes normally.
- start during busy is ignored. A start coinciding with done (FINISH) is also ignored.
- Reset mid-load: async reset clears the FSM and all strobes immediately. Neuron contents are undefined until the next full load.
- Width rule: weightValue and bias_value pass through unmodified. Any shift by fracWidth is the neuron's job.

Decomposition:
- Shared package/include holds:
  - FSM state encoding constants (ST_IDLE..ST_FINISH).
  - The config_* width expression 2*`dataWidth+1.
- One sub-module is natural: elm_param_counter, a wrap counter with terminal-count output, instanced for both w_cnt and n_cnt.

Test Plan:
- Setup for all scenarios: NUM_WEIGHT=4, NUM_NEURONS=2, LAYER_NO=1, NEURON_BASE=0.
- Nominal load: start, then 10 back-to-back beats 0x0001..0x000A, s_last on beat 10 →
  - neuron_clr pulse 1 cycle after start.
  - weightValid on beats 1-4 with neuron_num=0, then bias_valid=2'b01 value 0x0005.
  - weightValid on beats 6-9 with neuron_num=1, then bias_valid=2'b10 value 0x000A.
  - done 1 cycle later, err_last=0.
- Throttled input: same data with s_valid low every other cycle → identical strobe sequence, each strobe exactly 1 cycle after its accepted beat, no extra strobes.
- Early s_last: assert s_last on beat 3 → beat 3 weight is forwarded, err_last=1, done pulse, s_ready=0, no bias_valid issued.
- Missing s_last: 10 beats with no s_last → normal completion, done=1, err_last=1; the next start clears err_last.
- Start while busy: pulse start at beat 4 → no restart, no second neuron_clr, sequence is unchanged.
- Reset mid-load: drive rst=0 asynchronously between clock edges after beat 6 → all outputs 0 immediately. After release, a fresh start performs a full nominal load.
